bitserial_mac_unit_p: RTL and testbench

Parametrised bit-serial signed MAC.
- Multiplies a signed activation by a signed weight, one weight bit per cycle, LSB first. The last weight bit is subtracted (two's complement).
- Runtime precision selects full, half or quarter weight width.
- Accumulates the product into a wide signed accumulator.
- Uses a valid/ready input handshake. Sits in the PE array in place of the fixed 8-bit MAC and feeds the per-column result collector.

---
 rtl/bitserial_mac_unit_p_if.sv | 29 ++
 rtl/bitserial_mac_unit_p.sv | 127 ++++++++++++
 tb/tb_bitserial_mac_unit_p.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitserial_mac_unit_p_if.sv
// bitserial_mac_unit_p_if: operand handshake and result bus of the bit-serial MAC.
interface bitserial_mac_unit_p_if #(
    parameter int A_W   = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 20
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [A_W-1:0]       act;
    logic        [W_W-1:0]       wgt;
    logic        [1:0]           prec;
    logic                        acc_clr;
    logic                        busy;
    logic signed [A_W+W_W-1:0]   product;
    logic                        prod_valid;
    logic signed [ACC_W-1:0]     acc_out;
    logic                        acc_valid;
    logic                        sat_flag;

    modport master (
        output in_valid, act, wgt, prec, acc_clr,
        input  in_ready, busy, product, prod_valid, acc_out, acc_valid, sat_flag
    );

    modport slave (
        input  in_valid, act, wgt, prec, acc_clr,
        output in_ready, busy, product, prod_valid, acc_out, acc_valid, sat_flag
    );
endinterface

// File: rtl/bitserial_mac_unit_p.sv
// bitserial_mac_unit_p: bit-serial signed MAC, one weight bit per cycle, LSB first.
// Define MAC_SAT_EN for a saturating accumulator with a sticky sat_flag.
module bitserial_mac_unit_p #(
    parameter int A_W   = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 20
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    bitserial_mac_unit_p_if.slave  bus
);
    localparam int P_W = A_W + W_W;
    localparam int C_W = $clog2(W_W);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_ACCUM   = 2'd2;

    logic [1:0]              state;
    logic signed [A_W-1:0]   act_q;
    logic [W_W-1:0]          wgt_q;
    logic [C_W-1:0]          last_q;
    logic [C_W-1:0]          cnt;
    logic [C_W-1:0]          last_in;
    logic                    clr_q;
    logic signed [P_W-1:0]   psum;
    logic signed [P_W-1:0]   term;
    logic signed [P_W-1:0]   psum_nxt;
    logic signed [P_W-1:0]   product_q;
    logic                    prod_valid_q;
    logic                    acc_valid_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    accept;

    assign accept = en && state == S_IDLE && bus.in_valid;

    always_comb begin
        last_in  = bus.prec == 2'b01 ? C_W'(W_W/2 - 1) :
                   bus.prec == 2'b10 ? C_W'(W_W/4 - 1) : C_W'(W_W - 1);
        term     = P_W'(act_q) <<< cnt;
        // the top weight bit carries negative weight in two's complement
        psum_nxt = !wgt_q[cnt]   ? psum :
                   cnt == last_q ? psum - term : psum + term;
        base     = clr_q ? '0 : acc_q;
        prod_ext = ACC_W'(product_q);
        sum      = base + prod_ext;
    end

`ifdef MAC_SAT_EN
    logic ovf;
    logic sat_q;

    always_comb begin
        ovf     = base[ACC_W-1] == prod_ext[ACC_W-1] && sum[ACC_W-1] != base[ACC_W-1];
        acc_nxt = !ovf ? sum :
                  base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sat_q <= 1'b0;
        else if (accept && bus.acc_clr)
            sat_q <= 1'b0;
        else if (en && state == S_ACCUM && ovf)
            sat_q <= 1'b1;
    end

    assign bus.sat_flag = sat_q;
`else
    assign acc_nxt      = sum;
    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            act_q        <= '0;
            wgt_q        <= '0;
            last_q       <= '0;
            clr_q        <= 1'b0;
            cnt          <= '0;
            psum         <= '0;
            product_q    <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            acc_valid_q  <= 1'b0;
        end else if (en) begin
            prod_valid_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.in_valid) begin
                    act_q  <= bus.act;
                    wgt_q  <= bus.wgt;
                    last_q <= last_in;
                    clr_q  <= bus.acc_clr;
                    cnt    <= '0;
                    psum   <= '0;
                    state  <= S_COMPUTE;
                end
            end else if (state == S_COMPUTE) begin
                if (cnt == last_q) begin
                    product_q    <= psum_nxt;
                    prod_valid_q <= 1'b1;
                    state        <= S_ACCUM;
                end else begin
                    psum <= psum_nxt;
                    cnt  <= cnt + 1'b1;
                end
            end else begin
                acc_q       <= acc_nxt;
                acc_valid_q <= 1'b1;
                state       <= S_IDLE;
            end
        end
    end

    assign bus.in_ready   = state == S_IDLE;
    assign bus.busy       = state == S_COMPUTE || state == S_ACCUM;
    assign bus.product    = product_q;
    assign bus.prod_valid = prod_valid_q;
    assign bus.acc_out    = acc_q;
    assign bus.acc_valid  = acc_valid_q;
endmodule

// File: tb/tb_bitserial_mac_unit_p.sv
// tb_bitserial_mac_unit_p: randomized self-checking bench against an arithmetic reference model.
module tb_bitserial_mac_unit_p;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0;
    int checks = 0;
    int failures = 0;
    longint acc_m = 0;
    bit sat_m = 1'b0;

    always #5 clk = ~clk;

    bitserial_mac_unit_p_if #(.A_W(8), .W_W(8), .ACC_W(20)) m ();
    bitserial_mac_unit_p_if #(.A_W(8), .W_W(8), .ACC_W(16)) m16 ();

    bitserial_mac_unit_p #(.A_W(8), .W_W(8), .ACC_W(20)) u0 (.clk(clk), .rstn(rstn), .en(en), .bus(m));
    bitserial_mac_unit_p #(.A_W(8), .W_W(8), .ACC_W(16)) u16 (.clk(clk), .rstn(rstn), .en(en), .bus(m16));

    function automatic int prec_n(input logic [1:0] p);
        return p == 2'b01 ? 4 : p == 2'b10 ? 2 : 8;
    endfunction

    function automatic longint ref_prod(input longint a, input logic [7:0] w, input logic [1:0] p);
        int n;
        longint wv;
        n  = prec_n(p);
        wv = longint'(w) & ((64'sd1 <<< n) - 1);
        if (wv >= (64'sd1 <<< (n - 1)))
            wv -= (64'sd1 <<< n);
        return a * wv;
    endfunction

    function automatic longint ref_acc(input longint s, input int aw, output bit ovf);
        longint lim;
        lim = 64'sd1 <<< (aw - 1);
        ovf = (s >= lim) || (s < -lim);
`ifdef MAC_SAT_EN
        if (s >= lim) return lim - 1;
        if (s < -lim) return -lim;
        return s;
`else
        return ((s + lim) & ((lim <<< 1) - 1)) - lim;
`endif
    endfunction

    task automatic txn(input logic signed [7:0] a, input logic [7:0] w, input logic [1:0] p,
                       input logic c, input int stall_at, input int stall_len, input bit hold);
        longint ep, ea;
        int lat;
        bit o;
        ep = ref_prod(a, w, p);
        checks++;
        if (m.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_accept got=%b exp=1", m.in_ready);
        end
        m.in_valid = 1'b1; m.act = a; m.wgt = w; m.prec = p; m.acc_clr = c;
        @(posedge clk); #1;
`ifdef MAC_SAT_EN
        if (c) sat_m = 1'b0;
`endif
        ea = ref_acc((c ? 64'sd0 : acc_m) + ep, 20, o);
        if (!hold) m.in_valid = 1'b0;
        m.act = 8'($urandom); m.wgt = 8'($urandom); m.prec = 2'($urandom); m.acc_clr = 1'($urandom);
        checks++;
        if (m.in_ready !== 1'b0 || m.busy !== 1'b1 || m.acc_valid !== 1'b0) begin
            failures++;
            $display("FAIL accept got ready=%b busy=%b acc_valid=%b exp 0 1 0", m.in_ready, m.busy, m.acc_valid);
        end
        lat = 0;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            if (cyc == stall_at) en = 1'b0;
            if (cyc == stall_at + stall_len) en = 1'b1;
            @(posedge clk); #1;
            if (m.prod_valid === 1'b1)
                lat = cyc;
            else begin
                checks++;
                if (m.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_while_busy cyc=%0d got=%b exp=0", cyc, m.in_ready);
                end
            end
        end
        en = 1'b1;
        m.in_valid = 1'b0;
        checks++;
        if (lat != prec_n(p) + stall_len) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d", lat, prec_n(p) + stall_len);
        end
        checks++;
        if (m.product !== 16'(ep)) begin
            failures++;
            $display("FAIL product a=%0d w=%h p=%0d got=%0d exp=%0d", a, w, p, m.product, ep);
        end
        @(posedge clk); #1;
        checks++;
        if (m.acc_valid !== 1'b1 || m.prod_valid !== 1'b0 || m.in_ready !== 1'b1 || m.busy !== 1'b0) begin
            failures++;
            $display("FAIL accum_pulse got acc_valid=%b prod_valid=%b ready=%b busy=%b exp 1 0 1 0",
                     m.acc_valid, m.prod_valid, m.in_ready, m.busy);
        end
        checks++;
        if (m.acc_out !== 20'(ea)) begin
            failures++;
            $display("FAIL acc_out got=%0d exp=%0d", m.acc_out, ea);
        end
        acc_m = ea;
`ifdef MAC_SAT_EN
        if (o) sat_m = 1'b1;
`endif
        checks++;
        if (m.sat_flag !== sat_m) begin
            failures++;
            $display("FAIL sat_flag got=%b exp=%b", m.sat_flag, sat_m);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (m.product !== '0 || m.acc_out !== '0 || m.prod_valid !== 1'b0 || m.acc_valid !== 1'b0 ||
            m.sat_flag !== 1'b0 || m.in_ready !== 1'b1 || m.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s got prod=%0d acc=%0d pv=%b av=%b sat=%b ready=%b busy=%b exp all 0, ready=1",
                     tag, m.product, m.acc_out, m.prod_valid, m.acc_valid, m.sat_flag, m.in_ready, m.busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rstn = 1'b1;
        @(posedge clk); #1;
        check_zero("after_reset_release");
    endtask

    task automatic test_full();
        txn(8'sd5, 8'hFD, 2'b00, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_corner();
        txn(-8'sd128, 8'h80, 2'b00, 1'b1, 0, 0, 1'b0);
        txn(8'sd1, 8'h01, 2'b00, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_precision();
        txn(8'sd7, 8'hAD, 2'b01, 1'b1, 0, 0, 1'b0);
        txn(-8'sd1, 8'hF2, 2'b10, 1'b0, 0, 0, 1'b0);
        txn(8'sd100, 8'h9C, 2'b11, 1'b0, 0, 0, 1'b0);
        txn(-8'sd128, 8'hF8, 2'b01, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        txn(8'($urandom), 8'($urandom), 2'b00, 1'b0, 3, 3, 1'b1);
        txn(8'($urandom), 8'($urandom), 2'b01, 1'b0, 2, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            txn(8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        m.in_valid = 1'b1; m.act = 8'sd77; m.wgt = 8'h5B; m.prec = 2'b00; m.acc_clr = 1'b0;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_zero("reset_mid_compute");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (m.prod_valid !== 1'b0 || m.acc_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_pulse got pv=%b av=%b exp 0 0", m.prod_valid, m.acc_valid);
            end
        end
        rstn = 1'b1;
        acc_m = 0;
        sat_m = 1'b0;
        @(posedge clk); #1;
        txn(8'($urandom), 8'($urandom), 2'b00, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            txn(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0), 0, 0, 1'b0);
    endtask

    task automatic run16(input logic signed [7:0] a, input logic [7:0] w, input logic c);
        bit done;
        m16.in_valid = 1'b1; m16.act = a; m16.wgt = w; m16.prec = 2'b00; m16.acc_clr = c;
        @(posedge clk); #1;
        m16.in_valid = 1'b0;
        if (c) begin
            checks++;
            if (m16.sat_flag !== 1'b0) begin
                failures++;
                $display("FAIL sat_clear_on_accept got=%b exp=0", m16.sat_flag);
            end
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (m16.acc_valid === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL acc16_timeout got=no_acc_valid exp=acc_valid");
        end
    endtask

    task automatic test_overflow();
        longint e, base16;
        bit o, sat16;
        sat16 = 1'b0;
        m16.in_valid = 1'b0; m16.act = '0; m16.wgt = '0; m16.prec = '0; m16.acc_clr = 1'b0;
        run16(-8'sd128, 8'h80, 1'b1);
        base16 = ref_acc(ref_prod(-128, 8'h80, 2'b00), 16, o);
        checks++;
        if (m16.acc_out !== 16'(base16)) begin
            failures++;
            $display("FAIL acc16_first got=%0d exp=%0d", m16.acc_out, base16);
        end
        run16(-8'sd128, 8'h80, 1'b0);
        e = ref_acc(base16 + ref_prod(-128, 8'h80, 2'b00), 16, o);
`ifdef MAC_SAT_EN
        sat16 = o;
`endif
        checks++;
        if (m16.acc_out !== 16'(e) || m16.sat_flag !== sat16) begin
            failures++;
            $display("FAIL acc16_overflow got acc=%0d sat=%b exp acc=%0d sat=%b", m16.acc_out, m16.sat_flag, e, sat16);
        end
        run16(8'sd0, 8'h00, 1'b0);
        checks++;
        if (m16.acc_out !== 16'(e) || m16.sat_flag !== sat16) begin
            failures++;
            $display("FAIL sat_sticky got acc=%0d sat=%b exp acc=%0d sat=%b", m16.acc_out, m16.sat_flag, e, sat16);
        end
        run16(8'sd1, 8'h01, 1'b1);
        checks++;
        if (m16.acc_out !== 16'sd1) begin
            failures++;
            $display("FAIL acc16_clear got=%0d exp=1", m16.acc_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m.in_valid = 1'b0; m.act = '0; m.wgt = '0; m.prec = '0; m.acc_clr = 1'b0;
        m16.in_valid = 1'b0; m16.act = '0; m16.wgt = '0; m16.prec = '0; m16.acc_clr = 1'b0;
        en = 1'b1;
        test_reset();
        test_full();
        test_corner();
        test_precision();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
